// File: rtl/iagc_mem_ctrl.sv
// IAGC sample memory sequencer: owns the status bus, write/read addresses,
// sample/command arbitration and dump pacing. Optional macro: IAGC_CIRCULAR_BUF_EN.
module iagc_mem_ctrl #(
  parameter int DATA_SIZE        = 16,
  parameter int ADDR_SIZE        = 12,
  parameter int MEMORY_SIZE      = 1024,
  parameter int IAGC_STATUS_SIZE = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_sample_valid,
  input  logic                        i_cmd_valid,
  input  logic [7:0]                  i_cmd,
  input  logic                        i_tx_ready,
  input  logic                        i_clean_end,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
  output logic [ADDR_SIZE-1:0]        o_waddr,
  output logic [ADDR_SIZE-1:0]        o_raddr,
  output logic                        o_dump_valid,
  output logic                        o_dump_last,
  output logic [ADDR_SIZE-1:0]        o_fill,
  output logic                        o_full,
  output logic                        o_overrun,
  output logic                        o_cmd_error
);

  typedef enum logic [3:0] {
    ST_RESET     = 4'b0000,
    ST_INIT      = 4'b0001,
    ST_IDLE      = 4'b0010,
    ST_SAMPLE    = 4'b0011,
    ST_CMD_PARSE = 4'b0100,
    ST_CMD_READ  = 4'b0101,
    ST_CMD_ERROR = 4'b0110,
    ST_DUMP_MEM  = 4'b0111,
    ST_CLEAN_MEM = 4'b1000
  } state_t;

  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] MEM_WORDS = ADDR_SIZE'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE-1:0] MEM_LAST  = ADDR_SIZE'(MEMORY_SIZE - 1);

  if (DATA_SIZE < 1 || MEMORY_SIZE < 2 || MEMORY_SIZE >= (1 << ADDR_SIZE)) begin : g_cfg_check
    $error("iagc_mem_ctrl: inconsistent DATA_SIZE/ADDR_SIZE/MEMORY_SIZE");
  end

  state_t               state_r, state_nxt_s;
  logic [7:0]           cmd_r, cmd_nxt_s;
  logic                 run_r, run_nxt_s;
  logic [ADDR_SIZE-1:0] waddr_r, waddr_nxt_s;
  logic [ADDR_SIZE-1:0] raddr_r, raddr_nxt_s;
  logic [ADDR_SIZE-1:0] fill_r, fill_nxt_s;
  logic [ADDR_SIZE-1:0] dump_cnt_r, dump_cnt_nxt_s;
  logic                 full_r, full_nxt_s;
  logic                 overrun_r, overrun_nxt_s;
  logic                 dump_valid_r, dump_valid_nxt_s;
  logic                 dump_last_r, dump_last_nxt_s;
  logic                 cmd_error_r, cmd_error_nxt_s;
  logic                 take_sample_s;
  logic                 drop_sample_s;

  // A strobe is dropped whenever sampling is armed (or halted by full) but not taken.
  assign take_sample_s = (state_r == ST_IDLE) && !i_cmd_valid && i_sample_valid
                         && run_r && !full_r;
  assign drop_sample_s = i_sample_valid && (run_r || full_r) && !take_sample_s;

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s      = state_r;
    cmd_nxt_s        = cmd_r;
    run_nxt_s        = run_r;
    waddr_nxt_s      = waddr_r;
    raddr_nxt_s      = raddr_r;
    fill_nxt_s       = fill_r;
    dump_cnt_nxt_s   = dump_cnt_r;
    full_nxt_s       = full_r;
    overrun_nxt_s    = overrun_r | drop_sample_s;
    dump_valid_nxt_s = dump_valid_r;
    dump_last_nxt_s  = dump_last_r;
    cmd_error_nxt_s  = 1'b0;

    case (state_r)
      ST_RESET: state_nxt_s = ST_INIT;
      ST_INIT:  state_nxt_s = ST_IDLE;

      ST_IDLE: begin
        if (i_cmd_valid) begin
          state_nxt_s = ST_CMD_READ;
          cmd_nxt_s   = i_cmd;
        end else if (take_sample_s) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_CMD_READ: state_nxt_s = ST_CMD_PARSE;

      ST_CMD_PARSE: begin
        case (cmd_r)
          8'h53: begin
            run_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
          8'h50: begin
            run_nxt_s   = 1'b0;
            state_nxt_s = ST_IDLE;
          end
          8'h44: begin
            if (fill_r == ADDR_ZERO) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s      = ST_DUMP_MEM;
              dump_cnt_nxt_s   = ADDR_ZERO;
              dump_valid_nxt_s = 1'b0;
              dump_last_nxt_s  = 1'b0;
`ifdef IAGC_CIRCULAR_BUF_EN
              // Oldest word sits at the write pointer once the buffer has wrapped.
              raddr_nxt_s = (fill_r == MEM_WORDS) ? waddr_r : ADDR_ZERO;
`else
              raddr_nxt_s = ADDR_ZERO;
`endif
            end
          end
          8'h43: state_nxt_s = ST_CLEAN_MEM;
          default: begin
            state_nxt_s     = ST_CMD_ERROR;
            cmd_error_nxt_s = 1'b1;
          end
        endcase
      end

      ST_CMD_ERROR: state_nxt_s = ST_IDLE;

      ST_SAMPLE: begin
        state_nxt_s = ST_IDLE;
        if (fill_r == MEM_WORDS) begin
          fill_nxt_s = fill_r;
        end else begin
          fill_nxt_s = fill_r + ADDR_ONE;
        end
        if (waddr_r < MEM_LAST) begin
          waddr_nxt_s = waddr_r + ADDR_ONE;
        end else begin
`ifdef IAGC_CIRCULAR_BUF_EN
          waddr_nxt_s = ADDR_ZERO;
`else
          waddr_nxt_s = waddr_r;
          full_nxt_s  = 1'b1;
          run_nxt_s   = 1'b0;
`endif
        end
      end

      ST_DUMP_MEM: begin
        // dump_valid_r low marks the address-apply (gap) cycle of each word.
        if (!dump_valid_r) begin
          dump_valid_nxt_s = 1'b1;
          dump_last_nxt_s  = (dump_cnt_r == (fill_r - ADDR_ONE));
        end else if (i_tx_ready) begin
          dump_valid_nxt_s = 1'b0;
          dump_last_nxt_s  = 1'b0;
          if (dump_last_r) begin
            state_nxt_s = ST_IDLE;
            raddr_nxt_s = ADDR_ZERO;
          end else begin
            dump_cnt_nxt_s = dump_cnt_r + ADDR_ONE;
`ifdef IAGC_CIRCULAR_BUF_EN
            raddr_nxt_s = (raddr_r == MEM_LAST) ? ADDR_ZERO : (raddr_r + ADDR_ONE);
`else
            raddr_nxt_s = raddr_r + ADDR_ONE;
`endif
          end
        end else begin
          dump_valid_nxt_s = dump_valid_r;
        end
      end

      ST_CLEAN_MEM: begin
        if (i_clean_end) begin
          state_nxt_s   = ST_IDLE;
          waddr_nxt_s   = ADDR_ZERO;
          fill_nxt_s    = ADDR_ZERO;
          full_nxt_s    = 1'b0;
          overrun_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_CLEAN_MEM;
        end
      end

      default: state_nxt_s = ST_RESET;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_r      <= ST_RESET;
      cmd_r        <= 8'h00;
      run_r        <= 1'b0;
      waddr_r      <= ADDR_ZERO;
      raddr_r      <= ADDR_ZERO;
      fill_r       <= ADDR_ZERO;
      dump_cnt_r   <= ADDR_ZERO;
      full_r       <= 1'b0;
      overrun_r    <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      cmd_error_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cmd_r        <= cmd_nxt_s;
      run_r        <= run_nxt_s;
      waddr_r      <= waddr_nxt_s;
      raddr_r      <= raddr_nxt_s;
      fill_r       <= fill_nxt_s;
      dump_cnt_r   <= dump_cnt_nxt_s;
      full_r       <= full_nxt_s;
      overrun_r    <= overrun_nxt_s;
      dump_valid_r <= dump_valid_nxt_s;
      dump_last_r  <= dump_last_nxt_s;
      cmd_error_r  <= cmd_error_nxt_s;
    end
  end

  assign o_iagc_status = IAGC_STATUS_SIZE'(state_r);
  assign o_waddr       = waddr_r;
  assign o_raddr       = raddr_r;
  assign o_fill        = fill_r;
  assign o_full        = full_r;
  assign o_overrun     = overrun_r;
  assign o_dump_valid  = dump_valid_r;
  assign o_dump_last   = dump_last_r;
  assign o_cmd_error   = cmd_error_r;

endmodule

// File: tb/tb_iagc_mem_ctrl.sv
// Directed, table-driven bench for iagc_mem_ctrl built with MEMORY_SIZE=8.
module tb_iagc_mem_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n, sv, cv, tx, ce;
  logic [7:0]    cmd;
  logic [3:0]    status;
  logic [AW-1:0] waddr, raddr, fill;
  logic          dv, dl, full, ovr, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       cv;
    logic [7:0] cmd;
    logic       sv;
    logic       ce;
    logic [3:0] st;
    int         wa;
    int         fl;
    logic       fu;
    logic       ov;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  int   n_split;

  iagc_mem_ctrl #(
    .DATA_SIZE(16), .ADDR_SIZE(AW), .MEMORY_SIZE(8), .IAGC_STATUS_SIZE(4)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample_valid(sv), .i_cmd_valid(cv),
    .i_cmd(cmd), .i_tx_ready(tx), .i_clean_end(ce), .o_iagc_status(status),
    .o_waddr(waddr), .o_raddr(raddr), .o_dump_valid(dv), .o_dump_last(dl),
    .o_fill(fill), .o_full(full), .o_overrun(ovr), .o_cmd_error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c_v, input logic [7:0] c, input logic s_v,
                       input logic t, input logic e);
    cv = c_v; cmd = c; sv = s_v; tx = t; ce = e;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic c_v, input logic [7:0] c, input logic s_v,
                              input logic e, input logic [3:0] st, input int wa,
                              input int fl, input logic fu, input logic ov, input logic er);
    vec_t v;
    v.cv = c_v; v.cmd = c; v.sv = s_v; v.ce = e; v.st = st;
    v.wa = wa; v.fl = fl; v.fu = fu; v.ov = ov; v.er = er;
    return v;
  endfunction

  task automatic run_vec(input int i);
    drive(tbl[i].cv, tbl[i].cmd, tbl[i].sv, 1'b0, tbl[i].ce);
    step();
    chk($sformatf("v%0d.status", i), int'(status), int'(tbl[i].st));
    chk($sformatf("v%0d.waddr", i), int'(waddr), tbl[i].wa);
    chk($sformatf("v%0d.fill", i), int'(fill), tbl[i].fl);
    chk($sformatf("v%0d.full", i), int'(full), int'(tbl[i].fu));
    chk($sformatf("v%0d.overrun", i), int'(ovr), int'(tbl[i].ov));
    chk($sformatf("v%0d.cmd_error", i), int'(err), int'(tbl[i].er));
    chk($sformatf("v%0d.dump_valid", i), int'(dv), 0);
  endtask

  initial begin
    // Part 1: start sampling, five strobes spaced four cycles apart.
    tbl.push_back(mk(1, 8'h53, 0, 0, 4'd5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(0, 8'h00, 1, 0, 4'd3, i, i, 0, 0, 0));
      for (int j = 0; j < 3; j++)
        tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, i + 1, i + 1, 0, 0, 0));
    end
    n_split = tbl.size();
    // Part 2: unknown command, then command/sample collision with 'P'.
    tbl.push_back(mk(1, 8'h5A, 0, 0, 4'd5, 5, 5, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 5, 5, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd6, 5, 5, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 5, 5, 0, 0, 0));
    tbl.push_back(mk(1, 8'h50, 1, 0, 4'd5, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 4'd2, 5, 5, 0, 1, 0));
    // Clean with the end flag ten cycles after entry; a command inside is ignored.
    tbl.push_back(mk(1, 8'h43, 0, 0, 4'd5, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd8, 5, 5, 0, 1, 0));
    for (int j = 0; j < 9; j++)
      tbl.push_back(mk(j == 2, 8'h53, 0, 0, 4'd8, 5, 5, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 4'd2, 0, 0, 0, 0, 0));
    // Dump of an empty memory returns straight to IDLE.
    tbl.push_back(mk(1, 8'h44, 0, 0, 4'd5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 0, 0, 0, 0, 0));
    // Restart and fill the 8-word memory; the ninth strobe is dropped.
    tbl.push_back(mk(1, 8'h53, 0, 0, 4'd5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        tbl.push_back(mk(0, 8'h00, 1, 0, 4'd3, k - 1, k - 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, (k < 8) ? k : 7, k, k == 8, 0, 0));
      end else begin
        tbl.push_back(mk(0, 8'h00, 1, 0, 4'd2, 7, 8, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 4'd2, 7, 8, 1, 1, 0));
      end
    end

    // Reset held three cycles, then RESET -> INIT -> IDLE.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("rst.status", int'(status), 0);
      chk("rst.zero", int'({waddr, raddr, fill, dv, dl, full, ovr, err}), 0);
    end
    rst_n = 1'b1;
    step();
    chk("rst.init", int'(status), 1);
    step();
    chk("rst.idle", int'(status), 2);
    step();
    chk("rst.idle2", int'(status), 2);
    chk("rst.idle2_zero", int'({waddr, raddr, fill, dv, dl, full, ovr, err}), 0);

    for (int i = 0; i < n_split; i++) run_vec(i);

    // Dump of five words, tx_ready low three cycles per word.
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step();
    chk("dump.read", int'(status), 5);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk("dump.parse", int'(status), 4);
    step();
    chk("dump.enter", int'(status), 7);
    chk("dump.enter_raddr", int'(raddr), 0);
    chk("dump.enter_dv", int'(dv), 0);
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 3; j++) begin
        drive(w == 1 && j == 1, 8'h53, 1'b0, 1'b0, 1'b0);
        step();
        chk($sformatf("dump%0d.status", w), int'(status), 7);
        chk($sformatf("dump%0d.dv", w), int'(dv), 1);
        chk($sformatf("dump%0d.last", w), int'(dl), (w == 4) ? 1 : 0);
        chk($sformatf("dump%0d.raddr", w), int'(raddr), w);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("acc%0d.dv", w), int'(dv), 0);
      chk($sformatf("acc%0d.last", w), int'(dl), 0);
      chk($sformatf("acc%0d.status", w), int'(status), (w < 4) ? 7 : 2);
      chk($sformatf("acc%0d.raddr", w), int'(raddr), (w < 4) ? w + 1 : 0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_dump.status", int'(status), 2);
    chk("post_dump.fill", int'(fill), 5);
    chk("post_dump.waddr", int'(waddr), 5);
    chk("post_dump.overrun", int'(ovr), 0);

    for (int i = n_split; i < tbl.size(); i++) run_vec(i);

    // Reset in the middle of a dump of the full memory.
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("mid.status", int'(status), 7);
    step();
    chk("mid.dv", int'(dv), 1);
    chk("mid.last", int'(dl), 0);
    rst_n = 1'b0;
    step();
    chk("mid.rst_status", int'(status), 0);
    chk("mid.rst_zero", int'({waddr, raddr, fill, dv, dl, full, ovr, err}), 0);
    rst_n = 1'b1;
    step();
    step();
    chk("mid.idle", int'(status), 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    chk("mid.run_cleared_status", int'(status), 2);
    chk("mid.run_cleared_ovr", int'(ovr), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
